pim_conv_sched: RTL and testbench
=================================

PIM_CONV_SCHED -- requirements
Module: pim_conv_sched

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 34: width of the feature vector driven to the conv array.
REQ-002 SHALL have parameter DEPTH, default 6: conv address width, giving 2^DEPTH rows.
REQ-003 SHALL have parameter ADC_P, default 8: width of the conv ADC output, signed two's complement.
REQ-004 SHALL have parameter LAT, default 1, range 1..4: cycles from a pim_en cycle to valid pim_out.
REQ-005 SHALL have parameter FIFO_D, default 4, power of 2 and at least 2: depth of the result FIFO.
REQ-006 SHALL have parameter ACC_W, default 16, at least ADC_P+DEPTH: accumulator width.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port req_valid, input, 1 bit: request offered.
REQ-010 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-011 SHALL have port req_feature, input, INPUT_SIZE bits: feature vector for the job.
REQ-012 SHALL have port req_start, input, DEPTH bits: first row address.
REQ-013 SHALL have port req_count, input, DEPTH+1 bits: number of rows, 0..2^DEPTH.
REQ-014 SHALL have port pim_en, output, 1 bit: conv enable, one read per high cycle.
REQ-015 SHALL have port pim_feature, output, INPUT_SIZE bits: vector driven to conv Input_feature.
REQ-016 SHALL have port pim_addr, output, DEPTH bits: row driven to conv Address.
REQ-017 SHALL have port pim_out, input, ADC_P bits: conv Output.
REQ-018 SHALL have port res_valid, output, 1 bit: result beat available.
REQ-019 SHALL have port res_ready, input, 1 bit: consumer accepts the result beat.
REQ-020 SHALL have port res_data, output, ACC_W bits: result, signed.
REQ-021 SHALL have port res_last, output, 1 bit: final beat of a job.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE and DRAIN; req_ready SHALL be high only in IDLE.
REQ-023 On acceptance, SHALL latch req_feature, req_start and req_count, then enter ISSUE, or DRAIN if count is 0.
REQ-024 In ISSUE, SHALL assert pim_en with pim_addr=(start+i) mod 2^DEPTH for i=0..count-1, in order, wrapping the address.
REQ-025 SHALL issue a read only when (reads in flight + FIFO occupancy) < FIFO_D, so that the FIFO never overflows.
REQ-026 SHALL capture pim_out exactly LAT cycles after each pim_en cycle, track in-flight reads with an LAT-deep valid shift register, and sign-extend the captured value to ACC_W.
REQ-027 After the last issue, SHALL move to DRAIN; SHALL return to IDLE in the cycle after the res_last beat handshakes.
REQ-028 Result output SHALL be a FIFO: res_data/res_last held stable while res_valid=1 and res_ready=0; FIFO read and write in the same cycle SHALL both be allowed.
REQ-029 For count=0, SHALL issue no pim_en and emit exactly one beat: res_data=0, res_last=1.
REQ-030 pim_feature SHALL hold the latched vector for the whole job; pim_en SHALL be 0 outside ISSUE.
REQ-031 A req_valid assertion during a busy job SHALL be ignored until IDLE.

Reset
REQ-032 rst high SHALL force IDLE, req_ready=1, pim_en=0, pim_addr=0, pim_feature=0, res_valid=0, res_data=0, res_last=0, and SHALL clear the FIFO, the in-flight shift register and the accumulator.
REQ-033 Reset asserted mid-job SHALL discard all pending reads and results; pim_out values returning after reset SHALL be ignored.

Configuration
REQ-034 With macro PIM_SCHED_ACC_EN defined, SHALL sum all captured values in an ACC_W wrapping accumulator and emit a single beat with res_last=1 holding the total.
REQ-035 Without PIM_SCHED_ACC_EN, SHALL emit one beat per row holding the sign-extended pim_out, with res_last=1 only on row count-1.

Verification
REQ-036 Reset, then start=3, count=4, res_ready=1, model returns addr*2 -> pim_addr 3,4,5,6; res_data 6,8,10,12; res_last on 12.
REQ-037 start=62, count=4 -> pim_addr 62,63,0,1 (wrap-around).
REQ-038 count=8, res_ready=0 -> exactly FIFO_D=4 pim_en pulses then stall; release res_ready -> remaining 4 issued, 8 beats in order.
REQ-039 count=0 -> no pim_en; one beat res_data=0, res_last=1; req_ready high again next cycle.
REQ-040 PIM_SCHED_ACC_EN defined, count=4, pim_out=-1 (8'hFF) each -> single beat res_data=16'hFFFC, res_last=1.
REQ-041 rst pulsed after 2 issues of a count=6 job -> all outputs at reset values next cycle; no res_valid from stale returns.

Source files
------------

// File: rtl/pim_conv_sched.sv
// Row-scan scheduler for a PIM conv array: walks rows, captures ADC results into a credit-limited FIFO.
// Define PIM_SCHED_ACC_EN to sum all rows of a job into one beat instead of one beat per row.
module pim_conv_sched #(
  parameter int INPUT_SIZE = 34,
  parameter int DEPTH      = 6,
  parameter int ADC_P      = 8,
  parameter int LAT        = 1,
  parameter int FIFO_D     = 4,
  parameter int ACC_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [INPUT_SIZE-1:0] req_feature,
  input  logic [DEPTH-1:0]      req_start,
  input  logic [DEPTH:0]        req_count,
  output logic                  pim_en,
  output logic [INPUT_SIZE-1:0] pim_feature,
  output logic [DEPTH-1:0]      pim_addr,
  input  logic [ADC_P-1:0]      pim_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_W-1:0]      res_data,
  output logic                  res_last
);
  localparam int PW = $clog2(FIFO_D);
  localparam int CW = $clog2(FIFO_D + LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [INPUT_SIZE-1:0] r_feature;
  logic [DEPTH-1:0]      r_addr;
  logic [DEPTH:0]        r_issue_left, r_cap_left;
  logic                  r_done;
  logic [LAT-1:0]        r_vld_pipe;
  logic [ACC_W-1:0]      r_fifo_data [FIFO_D];
  logic [FIFO_D-1:0]     r_fifo_last;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [PW:0]           r_occ;

  logic             w_accept, w_issue, w_cap, w_final, w_push, w_push_last, w_pop;
  logic [ACC_W-1:0] w_ext, w_push_data;
  logic [CW-1:0]    w_inflight;

  assign w_cap    = r_vld_pipe[LAT-1];
  assign w_ext    = {{(ACC_W-ADC_P){pim_out[ADC_P-1]}}, pim_out};
  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_pop    = res_valid && res_ready;
  // Closing beat: everything captured but no last beat queued yet (count=0 or accumulate mode).
  assign w_final  = (r_state == DRAIN) && (r_cap_left == '0) && !r_done;

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < LAT; k++) w_inflight = w_inflight + CW'(r_vld_pipe[k]);
  end

  // Credit check: every read in flight already owns a FIFO slot.
  assign w_issue = (r_state == ISSUE) && !rst &&
                   ((w_inflight + CW'(r_occ)) < CW'(FIFO_D));

`ifdef PIM_SCHED_ACC_EN
  logic [ACC_W-1:0] r_acc;
  always_ff @(posedge clk) begin
    if (rst || w_accept) r_acc <= '0;
    else if (w_cap)      r_acc <= r_acc + w_ext;
  end
  assign w_push      = w_final;
  assign w_push_data = r_acc;
  assign w_push_last = 1'b1;
`else
  assign w_push      = w_cap || w_final;
  assign w_push_data = w_cap ? w_ext : '0;
  assign w_push_last = w_final || (r_cap_left == (DEPTH+1)'(1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_state_nxt = (req_count == '0) ? DRAIN : ISSUE;
      ISSUE:   if (w_issue && (r_issue_left == (DEPTH+1)'(1))) w_state_nxt = DRAIN;
      DRAIN:   if (w_pop && res_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_feature    <= '0;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_cap_left   <= '0;
      r_done       <= 1'b0;
      r_vld_pipe   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_vld_pipe[0] <= w_issue;
      for (int k = 1; k < LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
      if (w_accept) begin
        r_feature    <= req_feature;
        r_addr       <= req_start;
        r_issue_left <= req_count;
        r_cap_left   <= req_count;
        r_done       <= 1'b0;
      end else begin
        if (w_issue) begin
          r_addr       <= r_addr + 1'b1;
          r_issue_left <= r_issue_left - 1'b1;
        end
        if (w_cap) r_cap_left <= r_cap_left - 1'b1;
        if (w_push && w_push_last) r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
      r_fifo_last <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_push_data;
        r_fifo_last[r_wr_ptr] <= w_push_last;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign pim_en      = w_issue;
  assign pim_feature = r_feature;
  assign pim_addr    = r_addr;
  assign res_valid   = (r_occ != '0);
  assign res_data    = res_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign res_last    = res_valid && r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_pim_conv_sched.sv
// Directed bench for pim_conv_sched with a LAT=1 conv model; handles both accumulate and per-row builds.
module tb_pim_conv_sched;
  localparam int INPUT_SIZE = 34, DEPTH = 6, ADC_P = 8, LAT = 1, FIFO_D = 4, ACC_W = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, pim_en, res_valid, res_ready = 1'b0, res_last;
  logic [INPUT_SIZE-1:0] req_feature = '0, pim_feature;
  logic [DEPTH-1:0]      req_start = '0, pim_addr;
  logic [DEPTH:0]        req_count = '0;
  logic [ADC_P-1:0]      pim_out = '0, m_val = '0;
  logic [ACC_W-1:0]      res_data;

  int checks = 0, errors = 0;
  int model_mode = 0;
  int addr_q[$];
  logic [ACC_W-1:0] data_q[$];
  logic last_q[$];
  int exp_addr[$];
  logic [ACC_W-1:0] exp_data[$];

  always #5 clk = ~clk;

  pim_conv_sched #(.INPUT_SIZE(INPUT_SIZE), .DEPTH(DEPTH), .ADC_P(ADC_P), .LAT(LAT),
                   .FIFO_D(FIFO_D), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_feature(req_feature), .req_start(req_start), .req_count(req_count),
    .pim_en(pim_en), .pim_feature(pim_feature), .pim_addr(pim_addr), .pim_out(pim_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
  );

  // Conv model: a read seen in a cycle returns its value during the following cycle.
  always @(negedge clk) begin
    m_val = 8'h55;
    if (pim_en) m_val = (model_mode == 0) ? {1'b0, pim_addr, 1'b0} : 8'hFF;
    if (!rst && pim_en) addr_q.push_back(int'(pim_addr));
    if (!rst && res_valid && res_ready) begin
      data_q.push_back(res_data);
      last_q.push_back(res_last);
    end
  end
  always @(posedge clk) pim_out <= m_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [INPUT_SIZE-1:0] f, input int start, input int cnt);
    addr_q.delete(); data_q.delete(); last_q.delete();
    chk("req_ready_idle", req_ready, 1);
    req_feature = f; req_start = DEPTH'(start); req_count = (DEPTH+1)'(cnt); req_valid = 1'b1;
    cyc();
    req_valid = 1'b0;
    chk("pim_feature_latched", pim_feature, f);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(last_q.size() > 0 && last_q[$]) && n < budget) begin cyc(); n++; end
    chk({tag, "_done_in_budget"}, n < budget, 1);
    chk({tag, "_ready_after_last"}, req_ready, 1);
  endtask

  task automatic check_job(input string tag);
    chk({tag, "_naddr"}, addr_q.size(), exp_addr.size());
    foreach (exp_addr[i])
      if (i < addr_q.size()) chk($sformatf("%s_addr%0d", tag, i), addr_q[i], exp_addr[i]);
`ifdef PIM_SCHED_ACC_EN
    begin : acc_chk
      logic [ACC_W-1:0] sum;
      sum = '0;
      foreach (exp_data[i]) sum = sum + exp_data[i];
      chk({tag, "_nbeats"}, data_q.size(), 1);
      if (data_q.size() > 0) begin
        chk({tag, "_sum"}, data_q[0], sum);
        chk({tag, "_sum_last"}, last_q[0], 1);
      end
    end
`else
    chk({tag, "_nbeats"}, data_q.size(), exp_data.size());
    foreach (exp_data[i])
      if (i < data_q.size()) begin
        chk($sformatf("%s_data%0d", tag, i), data_q[i], exp_data[i]);
        chk($sformatf("%s_last%0d", tag, i), last_q[i], i == exp_data.size() - 1);
      end
`endif
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_pim_en", pim_en, 0);
    chk("rst_pim_addr", pim_addr, 0);
    chk("rst_pim_feature", pim_feature, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_last", res_last, 0);
    rst = 1'b0;
    cyc();

    // Basic job, addr*2 model
    res_ready = 1'b1; model_mode = 0;
    send(34'h2_1234_5678, 3, 4);
    wait_done("basic", 60);
    exp_addr = '{3, 4, 5, 6}; exp_data = '{16'd6, 16'd8, 16'd10, 16'd12};
    check_job("basic");
    cyc();

    // Address wrap
    send(34'h1_0F0F_0F0F, 62, 4);
    wait_done("wrap", 60);
    exp_addr = '{62, 63, 0, 1}; exp_data = '{16'd124, 16'd126, 16'd0, 16'd2};
    check_job("wrap");
    cyc();

    // Backpressure: credits stall issue at FIFO depth
    res_ready = 1'b0;
    send(34'h3_DEAD_BEEF, 1, 8);
    cyc(20);
`ifdef PIM_SCHED_ACC_EN
    chk("stall_pulses", addr_q.size(), 8);
    chk("stall_head_data", res_data, 72);
    chk("stall_head_last", res_last, 1);
    cyc(3);
    chk("stall_hold_data", res_data, 72);
`else
    chk("stall_pulses", addr_q.size(), FIFO_D);
    chk("stall_head_data", res_data, 2);
    chk("stall_head_last", res_last, 0);
    cyc(3);
    chk("stall_hold_data", res_data, 2);
`endif
    chk("stall_hold_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_done("stall", 100);
    exp_addr = '{1, 2, 3, 4, 5, 6, 7, 8};
    exp_data = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12, 16'd14, 16'd16};
    check_job("stall");
    cyc();

    // Zero-count job
    send(34'h0_0000_00AA, 9, 0);
    wait_done("zero", 30);
    exp_addr = {}; exp_data = '{16'd0};
    check_job("zero");
    cyc();

    // Negative ADC values, sign extension / wrapping sum
    model_mode = 1;
    send(34'h2_AAAA_5555, 10, 4);
    wait_done("neg", 60);
    exp_addr = '{10, 11, 12, 13};
    exp_data = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    check_job("neg");
    cyc();

    // Reset mid-job
    model_mode = 0; res_ready = 1'b0;
    send(34'h1_2345_6789, 20, 6);
    begin : mid_rst
      int n = 0;
      while (addr_q.size() < 2 && n < 50) begin cyc(); n++; end
    end
    chk("midrst_two_issues", addr_q.size(), 2);
    rst = 1'b1;
    #1;
    chk("midrst_pim_en_in_rst", pim_en, 0);
    cyc();
    rst = 1'b0;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_pim_addr", pim_addr, 0);
    chk("midrst_pim_feature", pim_feature, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", res_data, 0);
    chk("midrst_res_last", res_last, 0);
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("midrst_no_stale%0d", i), res_valid, 0);
    end
    chk("midrst_no_beats", data_q.size(), 0);
    chk("midrst_no_new_issue", addr_q.size(), 2);

    // Recovery after reset
    send(34'h0_0000_0001, 5, 2);
    wait_done("recover", 40);
    exp_addr = '{5, 6}; exp_data = '{16'd10, 16'd12};
    check_job("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
